gate_sweep_ctrl: RTL and testbench



---
 rtl/gate_sweep_ctrl.sv | 131 +++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// Truth-table sweep controller: walks every input combination of a gate under test,
// samples its output after a settle interval and reports pass/fail. Optional macro:
// GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module gate_sweep_ctrl #(
  parameter int N_INPUTS      = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter logic [(1<<N_INPUTS)-1:0] EXP_TT = 4'b0001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [N_INPUTS-1:0] dut_in,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   fail_count,
  output logic [N_INPUTS-1:0] first_fail_vec
);

  localparam int                  NVEC     = 1 << N_INPUTS;
  localparam logic [N_INPUTS-1:0] VEC_LAST = N_INPUTS'(NVEC - 1);
  localparam logic [3:0]          CNT_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [N_INPUTS-1:0] vec_q, vec_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [N_INPUTS:0]   fail_count_q, fail_count_d;
  logic [N_INPUTS-1:0] first_fail_vec_q, first_fail_vec_d;
  logic                fail_seen_q, fail_seen_d;
  logic                pass_q, pass_d;
  logic                mismatch;
  logic                last_vec;

  always_comb begin
    state_d          = state_q;
    vec_d            = vec_q;
    cnt_d            = cnt_q;
    fail_count_d     = fail_count_q;
    first_fail_vec_d = first_fail_vec_q;
    fail_seen_d      = fail_seen_q;
    pass_d           = pass_q;
    last_vec         = 1'b0;

    // Anything that does not compare equal, including an unknown output, is a mismatch.
    mismatch = 1'b1;
    if (dut_out == EXP_TT[vec_q]) mismatch = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d          = SETTLE;
          vec_d            = '0;
          cnt_d            = '0;
          fail_count_d     = '0;
          first_fail_vec_d = '0;
          fail_seen_d      = 1'b0;
          pass_d           = 1'b0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          fail_count_d = fail_count_q + 1'b1;
          if (!fail_seen_q) begin
            first_fail_vec_d = vec_q;
            fail_seen_d      = 1'b1;
          end
        end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        last_vec = (vec_q == VEC_LAST) || mismatch;
`else
        last_vec = (vec_q == VEC_LAST);
`endif
        if (last_vec) begin
          state_d = DONE;
          pass_d  = (fail_count_d == '0);
        end else begin
          state_d = SETTLE;
          vec_d   = vec_q + 1'b1;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      vec_q            <= '0;
      cnt_q            <= '0;
      fail_count_q     <= '0;
      first_fail_vec_q <= '0;
      fail_seen_q      <= 1'b0;
      pass_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      vec_q            <= vec_d;
      cnt_q            <= cnt_d;
      fail_count_q     <= fail_count_d;
      first_fail_vec_q <= first_fail_vec_d;
      fail_seen_q      <= fail_seen_d;
      pass_q           <= pass_d;
    end
  end

  // The vector is only driven while the sweep is exercising the gate.
  assign dut_in         = (state_q == SETTLE || state_q == SAMPLE) ? vec_q : '0;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign fail_count     = fail_count_q;
  assign first_fail_vec = first_fail_vec_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: a table-driven gate model feeds dut_out and the expected
// results are derived from the gate table against the NOR reference.
module tb_gate_sweep_ctrl;

  localparam int         S      = 2;
  localparam int         NV     = 4;
  localparam logic [3:0] EXP    = 4'b0001;
  localparam logic [3:0] TT_NOR = 4'b0001;
  localparam logic [3:0] TT_OR  = 4'b1110;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] dut_in;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] fail_count;
  logic [1:0] first_fail_vec;
  logic [3:0] gate_tt;

  int total = 0;
  int bad   = 0;

  gate_sweep_ctrl #(.N_INPUTS(2), .SETTLE_CYCLES(S), .EXP_TT(EXP)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .dut_in        (dut_in),
    .dut_out       (dut_out),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail_count    (fail_count),
    .first_fail_vec(first_fail_vec)
  );

  always #5 clk = ~clk;

  always_comb dut_out = gate_tt[dut_in];

  // One sweep: start goes high in cycle 0; pa/pb are extra cycles with start high.
  task automatic sweep(input logic [3:0] tt, input int pa, input int pb);
    int   exp_fc;
    int   exp_first;
    int   done_cyc;
    int   vec;
    logic exp_pass;
    @(negedge clk);
    gate_tt   = tt;
    exp_fc    = 0;
    exp_first = 0;
    for (int i = 0; i < NV; i++) begin
      if (tt[i] != EXP[i]) begin
        if (exp_fc == 0) exp_first = i;
        exp_fc++;
      end
    end
    done_cyc = NV * (S + 1) + 1;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    if (exp_fc > 0) begin
      exp_fc   = 1;
      done_cyc = (exp_first + 1) * (S + 1) + 1;
    end
`endif
    exp_pass = (exp_fc == 0);

    total++;
    if (busy !== 1'b0 || dut_in !== 2'b00) begin
      bad++;
      $display("FAIL idle_before_start tt=%b busy=%b dut_in=%b want busy=0 dut_in=00", tt, busy, dut_in);
    end
    start = 1'b1;
    for (int c = 1; c <= done_cyc; c++) begin
      @(negedge clk);
      start = (c == pa) || (c == pb);
      total++;
      if (done !== (c == done_cyc)) begin
        bad++;
        $display("FAIL done_timing tt=%b cycle=%0d got=%b want=%b", tt, c, done, (c == done_cyc));
      end
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL busy tt=%b cycle=%0d got=%b want=1", tt, c, busy);
      end
      if (c < done_cyc) begin
        vec = (c - 1) / (S + 1);
        total++;
        if (dut_in !== 2'(vec)) begin
          bad++;
          $display("FAIL dut_in tt=%b cycle=%0d got=%b want=%0d", tt, c, dut_in, vec);
        end
      end
    end
    total++;
    if (pass !== exp_pass) begin
      bad++;
      $display("FAIL pass tt=%b got=%b want=%b", tt, pass, exp_pass);
    end
    total++;
    if (fail_count !== 3'(exp_fc)) begin
      bad++;
      $display("FAIL fail_count tt=%b got=%0d want=%0d", tt, fail_count, exp_fc);
    end
    total++;
    if (first_fail_vec !== 2'(exp_first)) begin
      bad++;
      $display("FAIL first_fail_vec tt=%b got=%0d want=%0d", tt, first_fail_vec, exp_first);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({dut_in, busy, done, pass, fail_count, first_fail_vec} !== 10'b0) begin
      bad++;
      $display("FAIL reset_values got dut_in=%b busy=%b done=%b pass=%b fc=%0d ffv=%0d want all 0",
               dut_in, busy, done, pass, fail_count, first_fail_vec);
    end
    rst   = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_fixed_gates();
    sweep(TT_NOR, 0, 0);
    sweep(TT_OR, 0, 0);
    sweep(4'b0000, 0, 0);
    sweep(4'b1111, 0, 0);
  endtask

  task automatic test_back_to_back();
    int fc_hold;
    sweep(TT_NOR, 3, 13);
    fc_hold = int'(fail_count);
    sweep(TT_NOR, 0, 0);
    total++;
    if (int'(fail_count) !== fc_hold || pass !== 1'b1) begin
      bad++;
      $display("FAIL back_to_back_results got fc=%0d pass=%b want fc=%0d pass=1", fail_count, pass, fc_hold);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || pass !== 1'b1 || fail_count !== 3'd0) begin
      bad++;
      $display("FAIL results_hold got busy=%b pass=%b fc=%0d want busy=0 pass=1 fc=0", busy, pass, fail_count);
    end
  endtask

  task automatic test_mid_reset();
    int seen_done;
    @(negedge clk);
    gate_tt = TT_OR;
    start   = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 6) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (dut_in !== 2'b00 || busy !== 1'b0 || fail_count !== 3'd0 || done !== 1'b0 ||
        first_fail_vec !== 2'b00 || pass !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got dut_in=%b busy=%b fc=%0d done=%b ffv=%0d pass=%b want all 0",
               dut_in, busy, fail_count, done, first_fail_vec, pass);
    end
    seen_done = 0;
    repeat (16) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    total++;
    if (seen_done != 0) begin
      bad++;
      $display("FAIL mid_reset_quiet got active_cycles=%0d want 0", seen_done);
    end
    sweep(TT_NOR, 0, 0);
  endtask

  task automatic test_random_gates();
    for (int k = 0; k < 8; k++) begin
      sweep(4'($urandom_range(0, 15)), 0, 0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    gate_tt = TT_NOR;
    test_reset();
    test_fixed_gates();
    test_back_to_back();
    test_mid_reset();
    test_random_gates();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
